// File: rtl/watch_ctrl_multi.sv
// watch_ctrl_multi: BCD time-of-day watch with an alarm bank, alarm ring/timeout and stopwatch control.
// Ports: clk, rst (sync, active-high), tick (1 Hz enable), mode_btn/set_btn (one-cycle pulses);
//   hh_t..ss_u time digits; ah_t..am_u digits of alarm[alarm_idx]; alarm_en per-alarm enables;
//   alarm_idx/edit_idx edit position; state_out top state; en_sec_normal, en_sec_sw, save_split,
//   sel_sw, sw_clr stopwatch/display controls; alarm_hit, alarm_id, alarm_ring alarm status.
// Optional macro WATCH_SNOOZE_EN adds a snooze counter that re-rings SNOOZE_MIN minutes after an acknowledge.
module watch_ctrl_multi #(
    parameter int NUM_ALARMS   = 2,
    parameter int RING_SECONDS = 60,
    parameter int SNOOZE_MIN   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  mode_btn,
    input  logic                  set_btn,
    output logic [3:0]            hh_t,
    output logic [3:0]            hh_u,
    output logic [3:0]            mm_t,
    output logic [3:0]            mm_u,
    output logic [3:0]            ss_t,
    output logic [3:0]            ss_u,
    output logic [3:0]            ah_t,
    output logic [3:0]            ah_u,
    output logic [3:0]            am_t,
    output logic [3:0]            am_u,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [1:0]            alarm_idx,
    output logic [2:0]            edit_idx,
    output logic [1:0]            state_out,
    output logic                  en_sec_normal,
    output logic                  en_sec_sw,
    output logic                  save_split,
    output logic                  sel_sw,
    output logic                  sw_clr,
    output logic                  alarm_hit,
    output logic [1:0]            alarm_id,
    output logic                  alarm_ring
);
    typedef enum logic [1:0] {NORMAL = 2'b00, SET_TIME = 2'b01, SET_ALARM = 2'b10, STOP_WATCH = 2'b11} state_t;
    typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_SPLIT, SW_STOP} sw_t;

    if (NUM_ALARMS < 1 || NUM_ALARMS > 4 || RING_SECONDS < 1 || SNOOZE_MIN < 1) begin : g_bad_param
        $error("watch_ctrl_multi: illegal parameter value");
    end

    state_t            state_q, state_d;
    sw_t               sw_q, sw_d;
    logic [2:0]        edit_q, edit_d;
    logic [1:0]        aidx_q, aidx_d;
    logic [23:0]       tm_q, tm_d, tinc;
    // Bank is always 4 deep so a 2-bit alarm_idx indexes it directly; unused slots stay disabled.
    logic [3:0][15:0]  alm_q, alm_d;
    logic [3:0]        en_q, en_d;
    logic              sw_clr_q, sw_clr_d;
    logic              hit_q, hit_d;
    logic [1:0]        id_q, id_d;
    logic              ring_q, ring_d;
    logic [15:0]       rcnt_q, rcnt_d;
    logic              roll;
`ifdef WATCH_SNOOZE_EN
    logic              snz_on_q, snz_on_d;
    logic [15:0]       snz_cnt_q, snz_cnt_d;
`endif

    function automatic logic [23:0] tm_inc(input logic [23:0] t);
        logic [3:0] ht, hu, mt, mu, st, su;
        {ht, hu, mt, mu, st, su} = t;
        if (su != 4'd9) su = su + 4'd1;
        else begin
            su = 4'd0;
            if (st != 4'd5) st = st + 4'd1;
            else begin
                st = 4'd0;
                if (mu != 4'd9) mu = mu + 4'd1;
                else begin
                    mu = 4'd0;
                    if (mt != 4'd5) mt = mt + 4'd1;
                    else begin
                        mt = 4'd0;
                        if (ht == 4'd2 && hu == 4'd3) {ht, hu} = 8'h00;
                        else if (hu == 4'd9) {ht, hu} = {ht + 4'd1, 4'd0};
                        else hu = hu + 4'd1;
                    end
                end
            end
        end
        return {ht, hu, mt, mu, st, su};
    endfunction

    // One set press on hh:mm digit idx; stepping hh_t to 2 clamps an hh_u above 3 back to 0.
    function automatic logic [15:0] edit_digits(input logic [15:0] v, input logic [2:0] idx);
        logic [3:0] ht, hu, mt, mu;
        {ht, hu, mt, mu} = v;
        if (idx == 3'd0) begin
            ht = (ht >= 4'd2) ? 4'd0 : ht + 4'd1;
            hu = (ht == 4'd2 && hu > 4'd3) ? 4'd0 : hu;
        end
        if (idx == 3'd1) hu = (hu >= ((ht == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0 : hu + 4'd1;
        if (idx == 3'd2) mt = (mt >= 4'd5) ? 4'd0 : mt + 4'd1;
        if (idx == 3'd3) mu = (mu >= 4'd9) ? 4'd0 : mu + 4'd1;
        return {ht, hu, mt, mu};
    endfunction

    assign tinc = tm_inc(tm_q);

    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        edit_d   = edit_q;
        aidx_d   = aidx_q;
        tm_d     = tm_q;
        alm_d    = alm_q;
        en_d     = en_q;
        sw_clr_d = 1'b0;
        hit_d    = 1'b0;
        id_d     = id_q;
        ring_d   = ring_q;
        rcnt_d   = rcnt_q;
`ifdef WATCH_SNOOZE_EN
        snz_on_d  = snz_on_q;
        snz_cnt_d = snz_cnt_q;
`endif
        roll = 1'b0;
        if (tick && state_q != SET_TIME) begin
            tm_d = tinc;
            roll = tm_q[7:0] == 8'h59;
        end
        if (tick && ring_q) begin
            rcnt_d = rcnt_q - 16'd1;
            if (rcnt_q <= 16'd1) ring_d = 1'b0;
        end
        if (mode_btn) begin
            ring_d = 1'b0;
`ifdef WATCH_SNOOZE_EN
            if (ring_q) snz_on_d = 1'b0;
`endif
            case (state_q)
                NORMAL: begin
                    state_d = SET_TIME;
                    edit_d  = 3'd0;
                end
                SET_TIME: begin
                    if (edit_q == 3'd3) begin
                        tm_d[7:0] = 8'h00;
                        state_d   = SET_ALARM;
                        aidx_d    = 2'd0;
                        edit_d    = 3'd0;
                    end else edit_d = edit_q + 3'd1;
                end
                SET_ALARM: begin
                    if (edit_q != 3'd4) edit_d = edit_q + 3'd1;
                    else if (aidx_q < 2'(NUM_ALARMS - 1)) begin
                        aidx_d = aidx_q + 2'd1;
                        edit_d = 3'd0;
                    end else begin
                        state_d = STOP_WATCH;
                        aidx_d  = 2'd0;
                        edit_d  = 3'd0;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    sw_d    = SW_IDLE;
                end
            endcase
        end else if (set_btn) begin
            case (state_q)
                NORMAL: begin
                    if (ring_q) begin
                        ring_d = 1'b0;
`ifdef WATCH_SNOOZE_EN
                        snz_on_d  = 1'b1;
                        snz_cnt_d = 16'(SNOOZE_MIN * 60);
`endif
                    end
                end
                SET_TIME: tm_d[23:8] = edit_digits(tm_q[23:8], edit_q);
                SET_ALARM: begin
                    if (edit_q == 3'd4) en_d[aidx_q] = ~en_q[aidx_q];
                    else alm_d[aidx_q] = edit_digits(alm_q[aidx_q], edit_q);
                end
                default: begin
                    sw_clr_d = sw_q == SW_IDLE;
                    sw_d     = (sw_q == SW_RUN) ? SW_SPLIT : (sw_q == SW_SPLIT) ? SW_STOP : SW_RUN;
                end
            endcase
        end
`ifdef WATCH_SNOOZE_EN
        if (tick && snz_on_q) begin
            snz_cnt_d = snz_cnt_q - 16'd1;
            if (snz_cnt_q <= 16'd1) begin
                snz_on_d = 1'b0;
                hit_d    = 1'b1;
                ring_d   = 1'b1;
                rcnt_d   = 16'(RING_SECONDS);
            end
        end
`endif
        // Descending scan so the lowest matching index is the one that sticks.
        if (roll) begin
            for (int i = 3; i >= 0; i--) begin
                if (en_q[i] && alm_q[i] == tinc[23:8]) begin
                    hit_d  = 1'b1;
                    id_d   = 2'(i);
                    ring_d = 1'b1;
                    rcnt_d = 16'(RING_SECONDS);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            sw_q     <= SW_IDLE;
            edit_q   <= 3'd0;
            aidx_q   <= 2'd0;
            tm_q     <= 24'h0;
            alm_q    <= '0;
            en_q     <= 4'd0;
            sw_clr_q <= 1'b0;
            hit_q    <= 1'b0;
            id_q     <= 2'd0;
            ring_q   <= 1'b0;
            rcnt_q   <= 16'd0;
`ifdef WATCH_SNOOZE_EN
            snz_on_q  <= 1'b0;
            snz_cnt_q <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            edit_q   <= edit_d;
            aidx_q   <= aidx_d;
            tm_q     <= tm_d;
            alm_q    <= alm_d;
            en_q     <= en_d;
            sw_clr_q <= sw_clr_d;
            hit_q    <= hit_d;
            id_q     <= id_d;
            ring_q   <= ring_d;
            rcnt_q   <= rcnt_d;
`ifdef WATCH_SNOOZE_EN
            snz_on_q  <= snz_on_d;
            snz_cnt_q <= snz_cnt_d;
`endif
        end
    end

    assign {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u} = tm_q;
    assign {ah_t, ah_u, am_t, am_u} = alm_q[aidx_q];
    assign alarm_en      = en_q[NUM_ALARMS-1:0];
    assign alarm_idx     = aidx_q;
    assign edit_idx      = edit_q;
    assign state_out     = state_q;
    assign en_sec_normal = state_q != SET_TIME;
    assign en_sec_sw     = sw_q == SW_RUN || sw_q == SW_SPLIT;
    assign save_split    = sw_q == SW_SPLIT;
    assign sel_sw        = sw_q != SW_IDLE;
    assign sw_clr        = sw_clr_q;
    assign alarm_hit     = hit_q;
    assign alarm_id      = id_q;
    assign alarm_ring    = ring_q;
endmodule

// File: tb/tb_watch_ctrl_multi.sv
// tb_watch_ctrl_multi: directed self-checking bench for watch_ctrl_multi.
module tb_watch_ctrl_multi;
    logic clk = 1'b0, rst = 1'b0, tick = 1'b0, mode_btn = 1'b0, set_btn = 1'b0;
    logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, ah_t, ah_u, am_t, am_u;
    logic [1:0] alarm_en, alarm_idx, state_out, alarm_id;
    logic [2:0] edit_idx;
    logic en_sec_normal, en_sec_sw, save_split, sel_sw, sw_clr, alarm_hit, alarm_ring;
    logic [23:0] tm;
    logic [15:0] al;
    int checks = 0, failures = 0, hit_cnt = 0, h0;

    watch_ctrl_multi #(.NUM_ALARMS(2), .RING_SECONDS(60), .SNOOZE_MIN(5)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .set_btn(set_btn),
        .hh_t(hh_t), .hh_u(hh_u), .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
        .ah_t(ah_t), .ah_u(ah_u), .am_t(am_t), .am_u(am_u), .alarm_en(alarm_en),
        .alarm_idx(alarm_idx), .edit_idx(edit_idx), .state_out(state_out),
        .en_sec_normal(en_sec_normal), .en_sec_sw(en_sec_sw), .save_split(save_split),
        .sel_sw(sel_sw), .sw_clr(sw_clr), .alarm_hit(alarm_hit), .alarm_id(alarm_id),
        .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;
    assign tm = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u};
    assign al = {ah_t, ah_u, am_t, am_u};
    always @(posedge clk) if (alarm_hit === 1'b1) hit_cnt <= hit_cnt + 1;

    task automatic press(input logic m, input logic s);
        @(negedge clk); mode_btn = m; set_btn = s;
        @(negedge clk); mode_btn = 1'b0; set_btn = 1'b0;
    endtask
    task automatic modes(input int n); for (int i = 0; i < n; i++) press(1'b1, 1'b0); endtask
    task automatic sets(input int n); for (int i = 0; i < n; i++) press(1'b0, 1'b1); endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask
    task automatic do_reset;
        @(negedge clk); rst = 1'b1; tick = 1'b0; mode_btn = 1'b0; set_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (tm !== 24'h000000) begin failures++; $display("FAIL rst_time got=%h exp=000000", tm); end
        checks++; if (state_out !== 2'b00 || edit_idx !== 3'd0 || alarm_idx !== 2'd0) begin failures++; $display("FAIL rst_state got=%b/%0d/%0d exp=00/0/0", state_out, edit_idx, alarm_idx); end
        checks++; if ({alarm_en, alarm_hit, alarm_ring, alarm_id} !== 6'b0) begin failures++; $display("FAIL rst_alarm got=%b exp=000000", {alarm_en, alarm_hit, alarm_ring, alarm_id}); end
        checks++; if ({en_sec_normal, en_sec_sw, save_split, sel_sw, sw_clr} !== 5'b10000) begin failures++; $display("FAIL rst_ctrl got=%b exp=10000", {en_sec_normal, en_sec_sw, save_split, sel_sw, sw_clr}); end
        ticks(300);
        checks++; if (tm !== 24'h000500) begin failures++; $display("FAIL count_300 got=%h exp=000500", tm); end
        checks++; if (state_out !== 2'b00 || en_sec_normal !== 1'b1 || hit_cnt !== 0) begin failures++; $display("FAIL count_state got=%b/%b/%0d exp=00/1/0", state_out, en_sec_normal, hit_cnt); end
    endtask

    task automatic test_set_time;
        do_reset();
        modes(1);
        checks++; if (state_out !== 2'b01 || en_sec_normal !== 1'b0) begin failures++; $display("FAIL st_enter got=%b/%b exp=01/0", state_out, en_sec_normal); end
        sets(2); modes(1); sets(3); modes(1); sets(5); modes(1); sets(9);
        ticks(1);
        checks++; if (tm !== 24'h235900) begin failures++; $display("FAIL st_digits got=%h exp=235900", tm); end
        modes(1);
        checks++; if (state_out !== 2'b10 || edit_idx !== 3'd0 || alarm_idx !== 2'd0 || tm !== 24'h235900) begin failures++; $display("FAIL st_exit got=%b/%0d/%0d/%h exp=10/0/0/235900", state_out, edit_idx, alarm_idx, tm); end
        ticks(60);
        checks++; if (tm !== 24'h000000 || alarm_ring !== 1'b0) begin failures++; $display("FAIL day_wrap got=%h/%b exp=000000/0", tm, alarm_ring); end
        do_reset();
        modes(2); sets(9);
        checks++; if (tm !== 24'h090000) begin failures++; $display("FAIL hu_nine got=%h exp=090000", tm); end
        modes(15);
        checks++; if (state_out !== 2'b01 || edit_idx !== 3'd0) begin failures++; $display("FAIL cycle_back got=%b/%0d exp=01/0", state_out, edit_idx); end
        sets(1);
        checks++; if (tm !== 24'h190000) begin failures++; $display("FAIL ht_one got=%h exp=190000", tm); end
        sets(1);
        checks++; if (tm !== 24'h200000) begin failures++; $display("FAIL ht_clamp got=%h exp=200000", tm); end
        modes(1); sets(3);
        checks++; if (tm !== 24'h230000) begin failures++; $display("FAIL hu_23 got=%h exp=230000", tm); end
        sets(1);
        checks++; if (tm !== 24'h200000) begin failures++; $display("FAIL hu_mod4 got=%h exp=200000", tm); end
    endtask

    task automatic test_alarm_hit;
        do_reset();
        modes(5); modes(3); sets(2); modes(1); sets(1);
        checks++; if (alarm_en !== 2'b01 || al !== 16'h0002) begin failures++; $display("FAIL a0_prog got=%b/%h exp=01/0002", alarm_en, al); end
        modes(1);
        checks++; if (alarm_idx !== 2'd1 || al !== 16'h0000) begin failures++; $display("FAIL a1_select got=%0d/%h exp=1/0000", alarm_idx, al); end
        modes(6);
        h0 = hit_cnt;
        ticks(119);
        checks++; if (alarm_ring !== 1'b0 || hit_cnt !== h0 || state_out !== 2'b00) begin failures++; $display("FAIL pre_hit got=%b/%0d/%b exp=0/%0d/00", alarm_ring, hit_cnt, state_out, h0); end
        ticks(1);
        checks++; if (alarm_hit !== 1'b1 || alarm_id !== 2'd0 || alarm_ring !== 1'b1 || tm !== 24'h000200) begin failures++; $display("FAIL hit got=%b/%0d/%b/%h exp=1/0/1/000200", alarm_hit, alarm_id, alarm_ring, tm); end
        @(negedge clk);
        checks++; if (alarm_hit !== 1'b0 || hit_cnt !== h0 + 1) begin failures++; $display("FAIL hit_pulse got=%b/%0d exp=0/%0d", alarm_hit, hit_cnt, h0 + 1); end
        sets(1);
        checks++; if (alarm_ring !== 1'b0) begin failures++; $display("FAIL ack got=%b exp=0", alarm_ring); end
    endtask

    task automatic test_snooze;
        h0 = hit_cnt;
        ticks(300);
        @(negedge clk);
`ifdef WATCH_SNOOZE_EN
        checks++; if (hit_cnt !== h0 + 1 || alarm_id !== 2'd0 || alarm_ring !== 1'b1) begin failures++; $display("FAIL snooze got=%0d/%0d/%b exp=%0d/0/1", hit_cnt, alarm_id, alarm_ring, h0 + 1); end
`else
        checks++; if (hit_cnt !== h0 || alarm_ring !== 1'b0) begin failures++; $display("FAIL no_snooze got=%0d/%b exp=%0d/0", hit_cnt, alarm_ring, h0); end
`endif
    endtask

    task automatic test_alarm_priority;
        do_reset();
        modes(5); modes(3); sets(1); modes(1); sets(1);
        modes(1); modes(3); sets(1); modes(1); sets(1);
        modes(2);
        checks++; if (alarm_en !== 2'b11 || state_out !== 2'b00) begin failures++; $display("FAIL both_en got=%b/%b exp=11/00", alarm_en, state_out); end
        ticks(60);
        checks++; if (alarm_hit !== 1'b1 || alarm_id !== 2'd0) begin failures++; $display("FAIL lowest_id got=%b/%0d exp=1/0", alarm_hit, alarm_id); end
        modes(1);
        checks++; if (alarm_ring !== 1'b0 || state_out !== 2'b01) begin failures++; $display("FAIL mode_clr got=%b/%b exp=0/01", alarm_ring, state_out); end
        modes(3); sets(9); modes(1);
        modes(4); sets(1);
        checks++; if (alarm_en !== 2'b10 || tm !== 24'h000000) begin failures++; $display("FAIL a0_off got=%b/%h exp=10/000000", alarm_en, tm); end
        modes(7);
        ticks(60);
        checks++; if (alarm_hit !== 1'b1 || alarm_id !== 2'd1 || alarm_ring !== 1'b1) begin failures++; $display("FAIL id_one got=%b/%0d/%b exp=1/1/1", alarm_hit, alarm_id, alarm_ring); end
        ticks(59);
        checks++; if (alarm_ring !== 1'b1) begin failures++; $display("FAIL ring_59 got=%b exp=1", alarm_ring); end
        ticks(1);
        checks++; if (alarm_ring !== 1'b0) begin failures++; $display("FAIL ring_60 got=%b exp=0", alarm_ring); end
    endtask

    task automatic test_stopwatch;
        do_reset();
        modes(15);
        checks++; if (state_out !== 2'b11 || alarm_idx !== 2'd0 || {en_sec_sw, save_split, sel_sw, sw_clr} !== 4'b0000) begin failures++; $display("FAIL sw_enter got=%b/%0d/%b exp=11/0/0000", state_out, alarm_idx, {en_sec_sw, save_split, sel_sw, sw_clr}); end
        sets(1);
        checks++; if ({en_sec_sw, save_split, sel_sw, sw_clr} !== 4'b1011) begin failures++; $display("FAIL sw_run got=%b exp=1011", {en_sec_sw, save_split, sel_sw, sw_clr}); end
        @(negedge clk);
        checks++; if (sw_clr !== 1'b0 || en_sec_sw !== 1'b1) begin failures++; $display("FAIL sw_clr_pulse got=%b/%b exp=0/1", sw_clr, en_sec_sw); end
        sets(1);
        checks++; if ({en_sec_sw, save_split, sel_sw, sw_clr} !== 4'b1110) begin failures++; $display("FAIL sw_split got=%b exp=1110", {en_sec_sw, save_split, sel_sw, sw_clr}); end
        sets(1);
        checks++; if ({en_sec_sw, save_split, sel_sw, sw_clr} !== 4'b0010) begin failures++; $display("FAIL sw_stop got=%b exp=0010", {en_sec_sw, save_split, sel_sw, sw_clr}); end
        sets(1);
        checks++; if ({en_sec_sw, save_split, sel_sw, sw_clr} !== 4'b1010) begin failures++; $display("FAIL sw_rerun got=%b exp=1010", {en_sec_sw, save_split, sel_sw, sw_clr}); end
        modes(1);
        checks++; if (state_out !== 2'b00 || {en_sec_sw, save_split, sel_sw, sw_clr} !== 4'b0000) begin failures++; $display("FAIL sw_exit got=%b/%b exp=00/0000", state_out, {en_sec_sw, save_split, sel_sw, sw_clr}); end
        modes(15); sets(1);
        press(1'b1, 1'b1);
        checks++; if (state_out !== 2'b00 || {en_sec_sw, save_split, sel_sw} !== 3'b000) begin failures++; $display("FAIL mode_wins got=%b/%b exp=00/000", state_out, {en_sec_sw, save_split, sel_sw}); end
        modes(15); sets(1);
        checks++; if (sw_clr !== 1'b1 || en_sec_sw !== 1'b1) begin failures++; $display("FAIL sw_idle_again got=%b/%b exp=1/1", sw_clr, en_sec_sw); end
    endtask

    initial begin
        test_reset();
        test_set_time();
        test_alarm_hit();
        test_snooze();
        test_alarm_priority();
        test_stopwatch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/watch_ctrl_multi.md
Name: watch_ctrl_multi

Overview:
Second-generation watch controller that owns the BCD time-of-day counter (hh:mm:ss), a parametrised bank of NUM_ALARMS alarms, and the stopwatch control sub-FSM. It is driven by single-cycle debounced mode and set button pulses. A 1 Hz tick enable advances time, so clk can be fast. It adds per-alarm enable, alarm match and ring timeout, and all alarm, time-edit and stopwatch behaviour is specified below.

Parameters:
NUM_ALARMS, 2, number of alarm registers; legal range 1..4.
RING_SECONDS, 60, number of ticks alarm_ring stays high if nobody acknowledges it.
SNOOZE_MIN, 5, snooze delay in minutes; used only with WATCH_SNOOZE_EN.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tick  in  1  one-cycle pulse per second
mode_btn  in  1  one-cycle mode pulse
set_btn  in  1  one-cycle set pulse
hh_t, hh_u, mm_t, mm_u, ss_t, ss_u  out  4 each  time-of-day BCD digits
ah_t, ah_u, am_t, am_u  out  4 each  BCD digits of the alarm selected by alarm_idx
alarm_en  out  NUM_ALARMS  per-alarm enable bits
alarm_idx  out  2  alarm being edited; 0 outside SET_ALARM
edit_idx  out  3  sub-step being edited: 0=hh_t, 1=hh_u, 2=mm_t, 3=mm_u, 4=enable (enable step exists in SET_ALARM only)
state_out  out  2  00 NORMAL, 01 SET_TIME, 10 SET_ALARM, 11 STOP_WATCH
en_sec_normal, en_sec_sw, save_split, sel_sw, sw_clr  out  1 each  stopwatch/display controls
alarm_hit  out  1  one-cycle pulse on an alarm match
alarm_id  out  2  index of the last alarm that hit
alarm_ring  out  1  ringing level

Behaviour:
- Reset (synchronous, active-high):
  - All digits 00:00:00; all alarms 00:00 with alarm_en=0.
  - state NORMAL; edit_idx=0, alarm_idx=0; stopwatch sub-state SW_IDLE.
  - alarm_hit=0, alarm_ring=0, alarm_id=0.
  - en_sec_normal=1; en_sec_sw, save_split, sel_sw and sw_clr all 0.
  - Reset mid-edit or mid-ring discards all state.
- Time counting:
  - On tick, in every state except SET_TIME: ss increments, 59 wraps to 00 and carries into mm; mm 59 wraps and carries into hh; 23:59:59 wraps to 00:00:00.
  - In SET_TIME, ticks are ignored.
- en_sec_normal = 0 in SET_TIME, 1 in all other states.
- Mode/set priority: if mode_btn and set_btn are asserted in the same cycle, mode wins and set is dropped.
- NORMAL:
  - mode_btn: go to SET_TIME with edit_idx=0.
  - set_btn while ringing: acknowledge the ring. Otherwise set_btn has no effect.
- SET_TIME digit increment on set_btn:
  - hh_t: mod 3. If the new hh_t is 2 and hh_u>3, hh_u is cleared to 0 in the same cycle.
  - hh_u: mod 4 when hh_t=2, else mod 10.
  - mm_t: mod 6.
  - mm_u: mod 10.
- SET_TIME mode_btn:
  - At edit_idx 0..2: edit_idx+1.
  - At edit_idx 3: ss cleared to 00, go to SET_ALARM with alarm_idx=0, edit_idx=0.
- SET_ALARM:
  - Digit edit rules are identical to SET_TIME, applied to alarm[alarm_idx].
  - edit_idx 4: set_btn toggles alarm_en[alarm_idx].
  - mode_btn at edit_idx<4: edit_idx+1.
  - mode_btn at edit_idx 4: if alarm_idx<NUM_ALARMS-1, alarm_idx+1 and edit_idx=0; else go to STOP_WATCH with alarm_idx=0.
- STOP_WATCH sub-FSM on set_btn: SW_IDLE->SW_RUN->SW_SPLIT->SW_STOP->SW_RUN.
  - sw_clr: one-cycle pulse on the IDLE->RUN transition.
  - en_sec_sw = 1 in RUN and SPLIT.
  - save_split = 1 in SPLIT.
  - sel_sw = 1 in RUN, SPLIT and STOP.
  - mode_btn: go to NORMAL, sub-state returns to SW_IDLE, all four outputs drop in the same cycle the state changes.
- Output timing: state-decoded outputs are Moore outputs and change the cycle after the button pulse.
- Alarm match:
  - On a tick that rolls ss 59->00, compare the new hh:mm against every enabled alarm.
  - On any match: alarm_hit pulses high in the next cycle and alarm_id takes the lowest matching index.
  - alarm_ring goes high and its tick counter loads RING_SECONDS.
  - A new hit while ringing reloads the counter and updates alarm_id.
  - No match is evaluated in SET_TIME.
- Ring termination:
  - The counter decrements on each tick while ringing; ring clears when it reaches 0.
  - Acknowledge (set_btn in NORMAL) clears ring the next cycle.
  - mode_btn while ringing clears ring and also performs its normal transition.
  - Editing an alarm's digits does not cancel a ring already in progress.

Optional Feature:
- WATCH_SNOOZE_EN defined:
  - Acknowledge loads a snooze counter with SNOOZE_MIN*60 ticks.
  - At expiry: alarm_hit pulses with the same alarm_id and ring restarts.
  - mode_btn while ringing cancels any pending snooze.
  - Reset clears the snooze counter.
- WATCH_SNOOZE_EN undefined: no snooze counter exists, and acknowledge only clears ring.

Test Plan:
1. Reset, then 300 ticks -> time 00:05:00; state_out=00; en_sec_normal=1.
2. Set 23:59 (mode; set x2; mode; set x3; mode; set x5; mode; set x9; mode) -> state_out=10, ss=00. Then 60 ticks -> 00:00:00. Also, time 09:00 with hh_t stepped 0->1->2 -> hh_u clears to 0, giving 20:00.
3. Alarm0 = 00:02, enabled, at time 00:00:00 in NORMAL; 120 ticks -> alarm_hit high exactly 1 cycle, alarm_id=0, alarm_ring=1. Then set_btn -> ring 0 next cycle.
4. Alarm0 and alarm1 both 00:01 and enabled -> alarm_id=0. Disable alarm0 and repeat -> alarm_id=1. With no button, ring drops after exactly 60 ticks.
5. Stopwatch: each set_btn in turn gives sw_clr pulse and en_sec_sw=1, then save_split=1, then en_sec_sw=0 with sel_sw=1, then back to RUN; mode -> NORMAL with en_sec_sw=save_split=sel_sw=0. mode_btn and set_btn together in SW_RUN -> NORMAL, no sub-state advance.
6. With WATCH_SNOOZE_EN: acknowledge at hit, then 300 ticks -> second alarm_hit, same alarm_id. Without the macro, no second hit.
